dmem_uart_tx: RTL
=================

// Module: dmem_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter sitting on the rv32i data-memory bus beside d_mem.
//  Acts as the responder to the CPU's store/load port: same wr_en/wr_addr/rd_addr/mode/d_in/d_out signals as d_mem.
//  Buffers CPU-written bytes in a FIFO and serialises them 8N1 on tx.
//  Also latches a test-result word so benches read pass/fail from ports instead of peeking RAM.
// PARAMETERS
//  BASE_ADDR     8'hF0  byte address of register window (4 word registers, BASE..BASE+15)
//  FIFO_DEPTH    4      TX FIFO entries; power of 2, 2..8
//  CLKS_PER_BIT  16     reset value of DIVISOR (clk cycles per serial bit)
// PORTS
//  clk      in   1   clock, all state on rising edge
//  rst      in   1   asynchronous, active-high reset
//  wr_en    in   1   CPU store strobe
//  wr_addr  in   8   CPU store byte address
//  rd_addr  in   8   CPU load byte address
//  mode     in   2   access size 00 byte, 01 half, 10 word (d_mem encoding)
//  d_in     in   32  CPU store data
//  d_out    out  32  load data, combinational from rd_addr
//  tx       out  1   serial line, idle high
//  done     out  1   set by any write to RESULT; sticky until rst
//  result   out  32  last word written to RESULT
// BEHAVIOUR
//  Reset: tx=1, done=0, result=0, FIFO empty, overflow=0, DIVISOR=CLKS_PER_BIT, FSM=IDLE.
//  Register map (exact 8-bit address match; other addresses: writes ignored, d_out=0):
//   BASE+0 TXDATA  W: push d_in[7:0] (any mode). R: 0.
//   BASE+4 STATUS  R: [0]empty [1]full [2]busy(FSM!=IDLE) [3]overflow [7:4]count, rest 0. W: clears overflow.
//   BASE+8 DIVISOR R/W [15:0]; write of 0 stored as 1; new value used from next bit period.
//   BASE+C RESULT  R/W; write stores d_in into result, sets done. Byte mode stores d_in[7:0] zero-extended, half d_in[15:0].
//  FIFO: push on TXDATA write if not full; if full, byte dropped and overflow set (sticky).
//   Push and pop in same cycle legal at any count, including full (count unchanged, push accepted).
//  TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE: when FIFO non-empty, pop into shift reg, go START (pop visible the cycle after push).
//   START: tx=0 for DIVISOR clks. DATA: 8 bits LSB first, DIVISOR clks each, 3-bit bit counter.
//   STOP: tx=1 for DIVISOR clks, then IDLE; back-to-back frames with no extra idle cycle.
//   tx is a registered output (no glitches).
//   Baud counter reloads at each bit boundary; DIVISOR change mid-frame affects next bit only.
//  Simultaneous wr to RESULT and rd of RESULT: d_out shows old value that cycle.
//  rst mid-frame: tx returns to 1 immediately (async), FIFO contents discarded.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state between DATA and STOP sends even parity (XOR of data); frame 11 bits.
//  Not defined: no PARITY state, frame 10 bits (8N1).
// TESTING (sim with CLKS_PER_BIT=4, BASE_ADDR=F0)
//  1. Write 0x55 to F0 at cycle N -> tx=0 from N+2 for 4 clk, then 1,0,1,0,1,0,1,0, stop high; frame 40 clk.
//  2. Six TXDATA writes on consecutive cycles, idle FSM -> bytes 1-5 sent in order, 6th dropped; STATUS=0x4E after 6th.
//  3. Word write 0x00000001 to FC -> done=1, result=1 next cycle; read FC returns 1; done stays 1.
//  4. Write 0 to F8 -> read F8 returns 1; frame bits then last 1 clk each.
//  5. rst pulse mid DATA of byte 0xA3 with 2 queued -> tx=1 at once, STATUS reads 0x01 after release, no further frames.
//  6. With UART_TX_PARITY_EN, send 0x07 -> parity bit 1, frame 44 clk; without macro, frame 40 clk.

Source files
------------

// File: rtl/dmem_uart_tx.sv
// dmem_uart_tx: memory-mapped UART transmitter on the rv32i data-memory bus.
// Register window of four word registers at BASE_ADDR: TXDATA, STATUS, DIVISOR, RESULT.
// Bytes written to TXDATA are queued in a small FIFO and sent on tx, LSB first.
// RESULT latches a test-result word and raises a sticky done flag.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit (11-bit frame);
// without it the frame is plain 8N1 (10 bits).
module dmem_uart_tx #(
    parameter logic [7:0] BASE_ADDR    = 8'hF0,
    parameter int         FIFO_DEPTH   = 4,
    parameter int         CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_addr,
    input  logic [7:0]  rd_addr,
    input  logic [1:0]  mode,
    input  logic [31:0] d_in,
    output logic [31:0] d_out,
    output logic        tx,
    output logic        done,
    output logic [31:0] result
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [7:0]    ADDR_TXDATA  = BASE_ADDR;
    localparam logic [7:0]    ADDR_STATUS  = BASE_ADDR + 8'd4;
    localparam logic [7:0]    ADDR_DIVISOR = BASE_ADDR + 8'd8;
    localparam logic [7:0]    ADDR_RESULT  = BASE_ADDR + 8'd12;
    localparam logic [PW-1:0] PTR_ONE      = 1;
    localparam logic [CW-1:0] CNT_ONE      = 1;
    localparam logic [CW-1:0] CNT_FULL     = CW'(FIFO_DEPTH);
    localparam logic [15:0]   DIV_RESET    = 16'(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_t;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [3:0]    count4;
    logic          overflow;
    logic [15:0]   divisor;
    tx_state_t     state;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
`ifdef UART_TX_PARITY_EN
    logic          parity_bit;
`endif

    logic fifo_empty;
    logic fifo_full;
    logic busy;
    logic bit_end;
    logic wr_txdata;
    logic wr_status;
    logic wr_divisor;
    logic wr_result;
    logic pop;
    logic push;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);
    assign busy       = (state != ST_IDLE);
    assign bit_end    = (baud_cnt == 16'd0);
    assign count4     = 4'(count);

    assign wr_txdata  = wr_en && (wr_addr == ADDR_TXDATA);
    assign wr_status  = wr_en && (wr_addr == ADDR_STATUS);
    assign wr_divisor = wr_en && (wr_addr == ADDR_DIVISOR);
    assign wr_result  = wr_en && (wr_addr == ADDR_RESULT);

    // A pop happens when the line is free: idle, or at the very end of a stop bit so frames abut.
    assign pop  = !fifo_empty && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
    // A full FIFO still accepts a byte when the same cycle frees a slot.
    assign push = wr_txdata && (!fifo_full || pop);

    // FIFO storage; no reset needed because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= d_in[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag (cleared by any STATUS write).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (wr_txdata && !push) begin
                overflow <= 1'b1;
            end else if (wr_status) begin
                overflow <= 1'b0;
            end
        end
    end

    // Baud divisor register; zero is not a usable period so it is stored as one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divisor <= DIV_RESET;
        end else if (wr_divisor) begin
            divisor <= (d_in[15:0] == 16'd0) ? 16'd1 : d_in[15:0];
        end
    end

    // Test-result latch: stores the write sized by mode and raises done until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            done   <= 1'b0;
        end else if (wr_result) begin
            done <= 1'b1;
            case (mode)
                2'b00:   result <= {24'd0, d_in[7:0]};
                2'b01:   result <= {16'd0, d_in[15:0]};
                default: result <= d_in;
            endcase
        end
    end

    // Transmit FSM with registered tx; the baud counter reloads from DIVISOR at every bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            tx        <= 1'b1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (pop) begin
            shift_reg <= fifo_mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^fifo_mem[rd_ptr];
`endif
            tx        <= 1'b0;
            baud_cnt  <= divisor - 16'd1;
            state     <= ST_START;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                end
                ST_START: begin
                    if (bit_end) begin
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= 3'd0;
                        baud_cnt  <= divisor - 16'd1;
                        state     <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= divisor - 16'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= ST_PARITY;
`else
                            tx    <= 1'b1;
                            state <= ST_STOP;
`endif
                        end else begin
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                            bit_cnt   <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        tx       <= 1'b1;
                        baud_cnt <= divisor - 16'd1;
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        state <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Load data path; unmapped addresses and TXDATA read as zero.
    always_comb begin
        d_out = '0;
        case (rd_addr)
            ADDR_STATUS:  d_out = {24'd0, count4, overflow, busy, fifo_full, fifo_empty};
            ADDR_DIVISOR: d_out = {16'd0, divisor};
            ADDR_RESULT:  d_out = result;
            default:      d_out = '0;
        endcase
    end

endmodule
